pll_lock_supervisor: RTL and testbench

Lock supervisor for the 100 MHz system PLL, clocked from the PLL's own reference clock (24 MHz board oscillator) so it runs before any PLL output exists. It drives the PLL's active-high `reset` and consumes its `extlock`. It debounces lock, retries the PLL on lock timeout and enters a terminal fault after too many retries. Its `rst_out_n` is the root reset that downstream logic synchronises into the 100 MHz domain.

---
 rtl/pll_lock_supervisor.sv | 167 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the PLL reference clock: pulses the PLL reset, debounces
// extlock, retries on lock timeout and gates the system root reset.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 24,
  parameter int LOCK_TIMEOUT   = 24000,
  parameter int STABLE_CYCLES  = 2400,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       extlock,
  output logic       pll_reset,
  output logic       rst_out_n,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam int RW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            lock_s_q, lock_s_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [SW-1:0]   stb_cnt_q, stb_cnt_d;
  logic [3:0]      retry_cnt_q, retry_cnt_d;
  logic            lock_lost_q, lock_lost_d;
  logic            pll_reset_q, pll_reset_d;
  logic            rst_out_n_q, rst_out_n_d;
  logic            fault_q, fault_d;

  // extlock is asynchronous; only the second synchroniser stage feeds the FSM.
  always_comb begin
    sync1_d  = extlock;
    lock_s_d = sync1_q;
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retry_cnt_d = retry_cnt_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      S_RESET_PLL: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d  = S_WAIT_LOCK;
          to_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      // A lock sample beats a simultaneous timeout.
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          stb_cnt_d = SW'(1);
          if (STABLE_CYCLES == 1) begin
            state_d     = S_RUN;
            retry_cnt_d = '0;
          end else begin
            state_d = S_STABLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          if (retry_cnt_q == RETRY_MAX) begin
            state_d = S_FAULT;
          end else begin
            state_d     = S_RESET_PLL;
            rst_cnt_d   = '0;
            retry_cnt_d = retry_cnt_q + 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      // Dropping back to WAIT_LOCK keeps the timeout count, so chatter still times out.
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d     = S_RUN;
          retry_cnt_d = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (!lock_s_q) begin
          state_d     = S_RESET_PLL;
          rst_cnt_d   = '0;
          lock_lost_d = 1'b1;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d   = S_RESET_PLL;
        rst_cnt_d = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the transition.
  always_comb begin
    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    rst_out_n_d = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      retry_cnt_q <= '0;
      lock_lost_q <= 1'b0;
      pll_reset_q <= 1'b1;
      rst_out_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      lock_s_q    <= lock_s_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      lock_lost_q <= lock_lost_d;
      pll_reset_q <= pll_reset_d;
      rst_out_n_q <= rst_out_n_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign rst_out_n = rst_out_n_q;
  assign fault     = fault_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: per-cycle comparison against a phase
// model plus hand-computed edge counts for the key timing points.
module tb_pll_lock_supervisor;

  localparam int P = 4;
  localparam int T = 20;
  localparam int S = 8;
  localparam int R = 2;

  localparam int PH_RST   = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_STB   = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FAULT = 4;

  logic       refclk  = 1'b0;
  logic       rst_n   = 1'b0;
  logic       extlock = 1'b0;
  logic       pll_reset;
  logic       rst_out_n;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  // Model state: phase plus plain tallies of what the rules count.
  int m_ph     = PH_RST;
  int m_age    = 0;
  int m_miss   = 0;
  int m_streak = 0;
  int m_retry  = 0;
  int m_lost   = 0;
  int m_s1     = 0;
  int m_s2     = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (R)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .extlock  (extlock),
    .pll_reset(pll_reset),
    .rst_out_n(rst_out_n),
    .fault    (fault),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic model_step(input logic r, input logic x);
    int lk;
    if (!r) begin
      m_ph = PH_RST; m_age = 0; m_miss = 0; m_streak = 0;
      m_retry = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(x);
      case (m_ph)
        PH_RST: begin
          m_age++;
          if (m_age == P) begin
            m_ph   = PH_WAIT;
            m_miss = 0;
          end
        end
        PH_WAIT: begin
          if (lk != 0) begin
            m_streak = 1;
            if (m_streak >= S) begin
              m_ph = PH_RUN; m_retry = 0;
            end else begin
              m_ph = PH_STB;
            end
          end else begin
            m_miss++;
            if (m_miss == T) begin
              if (m_retry == R) begin
                m_ph = PH_FAULT;
              end else begin
                m_retry++; m_ph = PH_RST; m_age = 0;
              end
            end
          end
        end
        PH_STB: begin
          if (lk != 0) begin
            m_streak++;
            if (m_streak == S) begin
              m_ph = PH_RUN; m_retry = 0;
            end
          end else begin
            m_ph = PH_WAIT;
          end
        end
        PH_RUN: begin
          if (lk == 0) begin
            m_ph = PH_RST; m_age = 0; m_lost = 1;
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge refclk);
    ecnt++;
    model_step(rst_n, extlock);
    @(negedge refclk);
    chk("pll_reset", int'(pll_reset), (m_ph == PH_RST || m_ph == PH_FAULT) ? 1 : 0);
    chk("rst_out_n", int'(rst_out_n), (m_ph == PH_RUN) ? 1 : 0);
    chk("fault",     int'(fault),     (m_ph == PH_FAULT) ? 1 : 0);
    chk("lock_lost", int'(lock_lost), m_lost);
    chk("retry_cnt", int'(retry_cnt), m_retry);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_reset;
      1:       return rst_out_n;
      default: return fault;
    endcase
  endfunction

  // Ticks until the selected output equals val; n = ticks taken, -1 if the bound expires.
  task automatic ticks_until(input int sel, input logic val, input int limit, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < limit) begin
      tick();
      i++;
      if (sig(sel) == val) n = i;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    extlock = 1'b0;
    tick();
    tick();
    chk("rst_pll_reset", int'(pll_reset), 1);
    chk("rst_rst_out_n", int'(rst_out_n), 0);
    chk("rst_fault",     int'(fault),     0);
    chk("rst_lock_lost", int'(lock_lost), 0);
    chk("rst_retry_cnt", int'(retry_cnt), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;

    // Clean lock
    do_reset();
    ticks_until(0, 1'b0, 20, n);
    chk("s1_pll_rst_edges", n, 4);
    tick();
    tick();
    extlock = 1'b1;
    tick();
    ticks_until(1, 1'b1, 50, n);
    chk("s1_release_edges", n, 9);
    chk("s1_retry", int'(retry_cnt), 0);

    // Glitchy lock
    do_reset();
    ticks_until(0, 1'b0, 20, n);
    tick();
    tick();
    extlock = 1'b1;
    repeat (5) tick();
    extlock = 1'b0;
    tick();
    extlock = 1'b1;
    tick();
    chk("s2_held_at_rise", int'(rst_out_n), 0);
    ticks_until(1, 1'b1, 50, n);
    chk("s2_release_edges", n, 9);

    // Timeout, retries, fault, reset out of fault
    do_reset();
    ticks_until(0, 1'b0, 20, n);
    ticks_until(0, 1'b1, 40, n);
    chk("s3_timeout1", n, 20);
    chk("s3_retry1", int'(retry_cnt), 1);
    ticks_until(0, 1'b0, 20, n);
    chk("s3_pulse1", n, 4);
    ticks_until(0, 1'b1, 40, n);
    chk("s3_timeout2", n, 20);
    chk("s3_retry2", int'(retry_cnt), 2);
    ticks_until(0, 1'b0, 20, n);
    ticks_until(2, 1'b1, 40, n);
    chk("s3_fault_edges", n, 20);
    chk("s3_fault_pll_reset", int'(pll_reset), 1);
    chk("s3_fault_retry", int'(retry_cnt), 2);
    extlock = 1'b1;
    repeat (10) tick();
    chk("s3_fault_terminal", int'(fault), 1);
    chk("s3_fault_no_run", int'(rst_out_n), 0);
    rst_n = 1'b0;
    tick();
    chk("s5_fault_rst_fault", int'(fault), 0);
    chk("s5_fault_rst_retry", int'(retry_cnt), 0);
    chk("s5_fault_rst_pll", int'(pll_reset), 1);
    rst_n   = 1'b1;
    extlock = 1'b0;
    ticks_until(0, 1'b0, 20, n);
    chk("s5_restart_pulse", n, 4);

    // Lock loss and relock
    do_reset();
    extlock = 1'b1;
    ticks_until(1, 1'b1, 60, n);
    chk("s4_run_edges", n, 12);
    extlock = 1'b0;
    tick();
    ticks_until(1, 1'b0, 10, n);
    chk("s4_loss_edges", n, 2);
    chk("s4_loss_pll_reset", int'(pll_reset), 1);
    chk("s4_lock_lost", int'(lock_lost), 1);
    chk("s4_loss_retry", int'(retry_cnt), 0);
    extlock = 1'b1;
    ticks_until(1, 1'b1, 60, n);
    chk("s4_relock_edges", n, 12);
    chk("s4_lost_sticky", int'(lock_lost), 1);
    chk("s4_relock_retry", int'(retry_cnt), 0);

    // Reset while in STABLE with lock_lost set
    extlock = 1'b0;
    ticks_until(1, 1'b0, 10, n);
    extlock = 1'b1;
    repeat (7) tick();
    chk("s5_in_stable_pll", int'(pll_reset), 0);
    rst_n = 1'b0;
    tick();
    chk("s5_stb_rst_pll", int'(pll_reset), 1);
    chk("s5_stb_rst_lost", int'(lock_lost), 0);
    chk("s5_stb_rst_out", int'(rst_out_n), 0);
    rst_n = 1'b1;
    ticks_until(0, 1'b0, 20, n);
    chk("s5_stb_restart", n, 4);

    // Lock sample coincides with the 20th WAIT_LOCK edge after one retry
    do_reset();
    repeat (45) tick();
    extlock = 1'b1;
    repeat (3) tick();
    chk("s6_no_retry_pulse", int'(pll_reset), 0);
    chk("s6_retry_kept", int'(retry_cnt), 1);
    ticks_until(1, 1'b1, 30, n);
    chk("s6_release_edges", n, 7);
    chk("s6_retry_cleared", int'(retry_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
